// File: rtl/morse_frame_decoder_pkg.sv
// Shared Morse letter table and decoder state encodings; the encoder's
// charSelect uses the same constants so both ends of the link agree.
package morse_frame_decoder_pkg;

    localparam int MORSE_W = 14;

    localparam logic [MORSE_W-1:0] PAT_0 = 14'b10101000000000;
    localparam logic [MORSE_W-1:0] PAT_1 = 14'b11100000000000;
    localparam logic [MORSE_W-1:0] PAT_2 = 14'b10101110000000;
    localparam logic [MORSE_W-1:0] PAT_3 = 14'b10101110000000;
    localparam logic [MORSE_W-1:0] PAT_4 = 14'b10111011100000;
    localparam logic [MORSE_W-1:0] PAT_5 = 14'b11101010111000;
    localparam logic [MORSE_W-1:0] PAT_6 = 14'b11101011101110;
    localparam logic [MORSE_W-1:0] PAT_7 = 14'b11101110101000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DECIDE  = 2'd2
    } state_t;

    function automatic logic [MORSE_W-1:0] pattern_of(input logic [2:0] idx);
        logic [MORSE_W-1:0] p;
        case (idx)
            3'd0:    p = PAT_0;
            3'd1:    p = PAT_1;
            3'd2:    p = PAT_2;
            3'd3:    p = PAT_3;
            3'd4:    p = PAT_4;
            3'd5:    p = PAT_5;
            3'd6:    p = PAT_6;
            default: p = PAT_7;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/morse_frame_decoder_rom.sv
// Combinational reverse lookup of a captured frame into the letter table.
// The lowest matching index wins, so duplicate entries resolve downward.
module morse_pattern_rom
    import morse_frame_decoder_pkg::*;
(
    input  logic [MORSE_W-1:0] i_frame,
    output logic [2:0]         o_index,
    output logic               o_match
);

    always_comb begin
        o_index = 3'd0;
        o_match = 1'b0;
        // Scan downward so the last hit written is the lowest index.
        for (int i = 7; i >= 0; i--) begin
            if (i_frame == pattern_of(3'(i))) begin
                o_index = 3'(i);
                o_match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_frame_decoder.sv
// Reassembles a serial Morse frame sampled on each tick and decodes it
// against the letter table, pulsing code_valid or code_err per frame.
module morse_frame_decoder
    import morse_frame_decoder_pkg::*;
#(
    parameter int FRAME_W = 14,
    parameter int CNT_W   = 4
) (
    input  logic               clock,
    input  logic               Reset_b,
    input  logic               tick,
    input  logic               serial_in,
    output logic [2:0]         code_out,
    output logic               code_valid,
    output logic               code_err,
    output logic               busy,
    output logic [FRAME_W-1:0] frame_out
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [FRAME_W-1:0] r_shift;
    logic [FRAME_W-1:0] r_frame_out;
    logic [2:0]         r_code;
    logic               r_valid;
    logic               r_err;
    logic               r_busy;

    logic [MORSE_W-1:0] w_rom_frame;
    logic [2:0]         w_rom_index;
    logic               w_rom_match;

    assign w_rom_frame = r_shift;

    morse_pattern_rom u_rom (
        .i_frame (w_rom_frame),
        .o_index (w_rom_index),
        .o_match (w_rom_match)
    );

    always_ff @(posedge clock or negedge Reset_b) begin
        if (!Reset_b) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_frame_out <= '0;
            r_code      <= 3'd0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Every legal pattern starts with a 1; leading zeros are gap.
                    if (tick && serial_in) begin
                        r_shift <= {{(FRAME_W-1){1'b0}}, 1'b1};
                        r_cnt   <= CNT_W'(1);
                        r_state <= ST_CAPTURE;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (tick) begin
                        r_shift <= {r_shift[FRAME_W-2:0], serial_in};
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(FRAME_W-1))
                            r_state <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    r_frame_out <= r_shift;
                    if (w_rom_match) begin
                        r_code  <= w_rom_index;
                        r_valid <= 1'b1;
                    end else begin
                        r_err   <= 1'b1;
                    end
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign code_out   = r_code;
    assign code_valid = r_valid;
    assign code_err   = r_err;
    assign busy       = r_busy;
    assign frame_out  = r_frame_out;

endmodule

// File: tb/tb_morse_frame_decoder.sv
// Directed bench for morse_frame_decoder: ticks every 4 clocks, frames fed
// MSB first, results checked with immediate assertions.
module tb_morse_frame_decoder;

    logic        clock;
    logic        Reset_b;
    logic        tick;
    logic        serial_in;
    logic [2:0]  code_out;
    logic        code_valid;
    logic        code_err;
    logic        busy;
    logic [13:0] frame_out;

    int n_cmp;
    int n_fail;

    logic [13:0] tbl [8];

    morse_frame_decoder #(.FRAME_W(14), .CNT_W(4)) dut (
        .clock      (clock),
        .Reset_b    (Reset_b),
        .tick       (tick),
        .serial_in  (serial_in),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_err   (code_err),
        .busy       (busy),
        .frame_out  (frame_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bit per 4 clocks; entry and exit are 1 time unit after a posedge.
    task automatic tick_bit(input logic b);
        serial_in = b;
        tick      = 1'b1;
        @(posedge clock); #1;
        tick      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input string tag, input logic [13:0] pat);
        tick_bit(pat[13]);
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        for (int i = 12; i >= 1; i--) tick_bit(pat[i]);
        serial_in = pat[0];
        tick      = 1'b1;
        @(posedge clock); #1;
        tick      = 1'b0;
        chk({tag, "_valid_early"}, 32'(code_valid), 32'd0);
        chk({tag, "_busy_decide"}, 32'(busy), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic exp_v, input logic exp_e,
                                input logic [2:0] exp_code, input logic [13:0] exp_frame);
        @(posedge clock); #1;
        chk({tag, "_valid"}, 32'(code_valid), 32'(exp_v));
        chk({tag, "_err"},   32'(code_err),   32'(exp_e));
        chk({tag, "_code"},  32'(code_out),   32'(exp_code));
        chk({tag, "_frame"}, 32'(frame_out),  32'(exp_frame));
        chk({tag, "_busy"},  32'(busy),       32'd0);
        @(posedge clock); #1;
        chk({tag, "_pulse_end"}, 32'({code_valid, code_err}), 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        tick      = 1'b0;
        serial_in = 1'b0;
        Reset_b   = 1'b0;

        tbl[0] = 14'b10101000000000;
        tbl[1] = 14'b11100000000000;
        tbl[2] = 14'b10101110000000;
        tbl[3] = 14'b10101110000000;
        tbl[4] = 14'b10111011100000;
        tbl[5] = 14'b11101010111000;
        tbl[6] = 14'b11101011101110;
        tbl[7] = 14'b11101110101000;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_code",  32'(code_out),   32'd0);
        chk("rst_valid", 32'(code_valid), 32'd0);
        chk("rst_err",   32'(code_err),   32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_frame", 32'(frame_out),  32'd0);
        Reset_b = 1'b1;
        @(posedge clock); #1;

        // Test 1: letter 5
        send_frame("t1", 14'b11101010111000);
        check_result("t1", 1'b1, 1'b0, 3'd5, 14'h3AB8);

        // Test 4: no match keeps previous code (5)
        send_frame("t4", 14'b11111111111111);
        check_result("t4", 1'b0, 1'b1, 3'd5, 14'h3FFF);

        // Test 2: duplicate entry resolves to 2, then back-to-back letter 1
        send_frame("t2a", 14'b10101110000000);
        check_result("t2a", 1'b1, 1'b0, 3'd2, 14'b10101110000000);
        send_frame("t2b", 14'b11100000000000);
        check_result("t2b", 1'b1, 1'b0, 3'd1, 14'b11100000000000);

        // Test 5: async reset after 7 captured bits
        for (int i = 13; i >= 7; i--) tick_bit(tbl[7][i]);
        chk("t5_busy_pre", 32'(busy), 32'd1);
        @(negedge clock);
        Reset_b = 1'b0;
        #1;
        chk("t5_rst_code",  32'(code_out),  32'd0);
        chk("t5_rst_frame", 32'(frame_out), 32'd0);
        chk("t5_rst_busy",  32'(busy),      32'd0);
        chk("t5_rst_pulse", 32'({code_valid, code_err}), 32'd0);
        @(posedge clock); #1;
        Reset_b = 1'b1;
        @(posedge clock); #1;
        send_frame("t5", 14'b11101110101000);
        check_result("t5", 1'b1, 1'b0, 3'd7, 14'b11101110101000);

        // Test 3: leading zeros ignored, then letter 0
        for (int i = 0; i < 5; i++) tick_bit(1'b0);
        chk("t3_idle_busy", 32'(busy), 32'd0);
        send_frame("t3", 14'b10101000000000);
        check_result("t3", 1'b1, 1'b0, 3'd0, 14'b10101000000000);

        // Test 6: serialiser loop-back model over all switch settings
        for (int sw = 0; sw < 8; sw++) begin
            tick_bit(1'b0);
            send_frame($sformatf("t6_sw%0d", sw), tbl[sw]);
            check_result($sformatf("t6_sw%0d", sw), 1'b1, 1'b0,
                         (sw == 3) ? 3'd2 : 3'(sw), tbl[sw]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_frame_decoder.md
Name: morse_frame_decoder

Overview:
- Downstream consumer of the Morse letter serialiser.
- The serialiser emits one 14-bit Morse pattern, MSB first, one bit per rate-divider enable pulse. This block samples that serial stream on the same pulse and reassembles the 14-bit frame.
- It then matches the frame against the 8-entry letter table and reports the 3-bit letter select, or an error.
- Used for loop-back self-check on the board: serialiser output drives serial_in; decoded code goes to LEDR/HEX.

Parameters:
- FRAME_W, 14, bits per Morse frame (pattern width).
- CNT_W, 4, width of the bit counter; must satisfy 2**CNT_W > FRAME_W.

Ports:
- clock  in  1  system clock (CLOCK_50 at top level).
- Reset_b  in  1  asynchronous, active-low reset.
- tick  in  1  one-clock-wide enable pulse from rateDivider/enablePulse; the sample strobe.
- serial_in  in  1  serial Morse bit (shift register output).
- code_out  out  3  decoded letter select; holds until the next decision.
- code_valid  out  1  one-clock pulse: frame matched, code_out updated.
- code_err  out  1  one-clock pulse: frame matched no table entry.
- busy  out  1  high while a frame is being captured or decided.
- frame_out  out  FRAME_W  last captured frame, MSB = first bit received.

Behaviour:
- Clock and reset:
  - Single clock; all state updates on posedge clock.
  - Reset_b low forces immediately, regardless of clock: state=IDLE, counter=0, frame register=0, frame_out=0, code_out=0, code_valid=0, code_err=0, busy=0.
- State IDLE (busy=0):
  - A tick with serial_in=0 is ignored (inter-frame gap / leading zeros).
  - A tick with serial_in=1 (every valid pattern starts with 1):
    - shift reg <= {FRAME_W-1 zeros, 1};
    - counter <= 1;
    - state -> CAPTURE.
- State CAPTURE (busy=1):
  - On each tick: shift reg <= {shift reg[FRAME_W-2:0], serial_in}, counter <= counter+1.
  - The tick that captures the 14th bit (counter==FRAME_W-1 before the edge) moves state -> DECIDE.
  - Clock edges without tick change nothing.
- State DECIDE (busy=1, exactly one clock):
  - frame_out <= shift reg.
  - Compare the frame against table entries 0..7 in ascending order; the lowest matching index wins.
    - Entries 2 and 3 are identical (10101110000000), so that frame decodes to 2.
  - Match: code_out <= index, code_valid <= 1.
  - No match: code_out unchanged, code_err <= 1.
  - State -> IDLE.
  - A tick arriving during the DECIDE cycle is dropped; not sampled.
- Pulses:
  - code_valid and code_err are registered and high for exactly one clock, the cycle after the DECIDE edge.
  - They are never both high.
- Latency: 14th sampling edge E → DECIDE edge E+1 → code_valid high during cycle E+1..E+2.
- Back-to-back frames: a 1 sampled on the first tick after returning to IDLE starts a new frame immediately; no minimum gap is required.
- Table values (index: pattern):
  - 0: 10101000000000
  - 1: 11100000000000
  - 2: 10101110000000
  - 3: 10101110000000
  - 4: 10111011100000
  - 5: 11101010111000
  - 6: 11101011101110
  - 7: 11101110101000
- A tick held high for more than one clock samples on every high clock; upstream guarantees single-cycle ticks.

Decomposition:
- Shared include file holds:
  - the 8 pattern constants (shared with charSelect so encoder and decoder cannot diverge);
  - the state encodings IDLE=2'd0, CAPTURE=2'd1, DECIDE=2'd2.
- One sub-module, morse_pattern_rom: combinational, input 14-bit frame, outputs 3-bit index plus match flag, with lowest-index priority.
- The FSM, counter and shift register stay in morse_frame_decoder.

Test Plan:
- Setup for all tests: tick every 4 clocks.
- Test 1: feed 11101010111000 → after the 14th tick, code_valid pulses 1 clock, code_out=5, frame_out=0x3AB8, code_err=0.
- Test 2: feed 10101110000000 → code_out=2 (not 3), code_valid pulse; then feed 11100000000000 back-to-back on the next tick → code_out=1.
- Test 3: five ticks of serial_in=0, then 10101000000000 → leading zeros ignored, busy rises only on the first 1, code_out=0.
- Test 4: feed 11111111111111 → code_err pulses once, code_valid=0, code_out keeps its previous value, frame_out=0x3FFF.
- Test 5: assert Reset_b low mid-clock after 7 captured bits → all outputs 0 immediately (before the next edge), busy=0. After release, a full frame 11101110101000 decodes to 7.
- Test 6: loop-back with the real serialiser, SW=0..7 sequentially → code_out equals SW for each, except SW=3 → 2; no code_err.
